// File: rtl/bird_input_ctrl.sv
// -----------------------------------------------------------------------------
// bird_input_ctrl
//
// Producer side of the bird movement interface. Generates the periodic
// bird_move tick, turns push button KEY[3] into a debounced, rate-limited flap
// request, and emits a one-cycle start pulse when the button is pressed while
// the game is not running.
//
// Ports:
//   clk          in   system clock
//   RESET_GAME_N in   asynchronous active-low reset
//   KEY[3:0]     in   raw board buttons, active-low; only KEY[3] is used
//   run          in   game running; ticks and flaps are enabled only when 1
//   bird_move    out  one-cycle movement tick every TICK_DIV cycles
//   flap_req     out  level, pending flap to be applied on the next tick
//   start_pulse  out  one-cycle pulse on a press accepted while run = 0
//   key_pressed  out  debounced button state (1 = pressed)
// -----------------------------------------------------------------------------
module bird_input_ctrl #(
  parameter int TICK_DIV        = 833333,  // >= 2
  parameter int DEBOUNCE_CYCLES = 500000,  // >= 1
  parameter int HOLDOFF_TICKS   = 3        // 0 disables holdoff
) (
  input  logic       clk,
  input  logic       RESET_GAME_N,
  input  logic [3:0] KEY,
  input  logic       run,
  output logic       bird_move,
  output logic       flap_req,
  output logic       start_pulse,
  output logic       key_pressed
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_TICKS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic          sync1, sync2;
  logic [DW-1:0] db_cnt;
  logic          stable_lvl;
  logic          key_d;
  logic          press_evt;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  // KEY[2:0] are board buttons this block does not use.
  logic unused_key_bits;
  assign unused_key_bits = ^KEY[2:0];

  // Two-flop synchronizer; resets to the released (high) level so no phantom
  // press is seen on reset release.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes this a 2-stage chain.
  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= KEY[3];
      sync2 <= sync1;
    end
  end

  // Debounce: the stable level is held inverted in key_pressed. The counter
  // counts consecutive cycles where the synchronized level disagrees with the
  // stable level; any agreeing cycle (a bounce) restarts the count.
  assign stable_lvl = ~key_pressed;

  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      db_cnt      <= '0;
      key_pressed <= 1'b0;
    end else if (sync2 == stable_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt      <= '0;
      key_pressed <= ~key_pressed;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press event: registered rising edge of the debounced state. Releases
  // produce nothing. A press while idle starts the game instead of flapping.
  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      key_d       <= 1'b0;
      press_evt   <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      key_d       <= key_pressed;
      press_evt   <= key_pressed & ~key_d;
      start_pulse <= press_evt & ~run;
    end
  end

  // Tick generator: free-running modulo-TICK_DIV counter while running; held
  // at zero otherwise so a restart always yields a full first period.
  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      tick_cnt  <= '0;
      bird_move <= 1'b0;
    end else if (!run) begin
      tick_cnt  <= '0;
      bird_move <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt  <= '0;
      bird_move <= 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
      bird_move <= 1'b0;
    end
  end

  // Flap FSM. The consumer samples flap_req in the bird_move cycle, so that
  // cycle is the consumption point. A press arriving in the consumption cycle
  // is ignored, same as a press during holdoff.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (!run) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press_evt) state_nxt = ST_PENDING;
        end
        ST_PENDING: begin
          if (bird_move) begin
            if (HOLDOFF_TICKS == 0) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_HOLDOFF;
              hold_nxt  = HOLD_INIT;
            end
          end
        end
        ST_HOLDOFF: begin
          if (bird_move) begin
            hold_nxt = hold_cnt - 1'b1;
            if (hold_cnt == HOLD_ONE) state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign flap_req = (state == ST_PENDING);

endmodule

// File: tb/tb_bird_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bird_input_ctrl
//
// Self-checking bench for bird_input_ctrl with small parameters. A behavioural
// model (sliding window of synchronized samples, run-streak arithmetic for the
// tick, pending/holdoff bookkeeping) predicts all four outputs after every
// clock edge; one compare process checks them on each falling edge. Directed
// phases pin the model with hand-computed edge numbers, then a randomized
// phase drives KEY, run and occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_bird_input_ctrl;

  localparam int T = 4;  // TICK_DIV
  localparam int D = 3;  // DEBOUNCE_CYCLES
  localparam int H = 2;  // HOLDOFF_TICKS

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key   = 4'hF;
  logic       run   = 1'b1;
  logic       bird_move, flap_req, start_pulse, key_pressed;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = -1;  // index of the last clock edge since reset release

  always #10 clk = ~clk;

  bird_input_ctrl #(
    .TICK_DIV       (T),
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_TICKS  (H)
  ) dut (
    .clk         (clk),
    .RESET_GAME_N(rst_n),
    .KEY         (key),
    .run         (run),
    .bird_move   (bird_move),
    .flap_req    (flap_req),
    .start_pulse (start_pulse),
    .key_pressed (key_pressed)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, edge %0d)", name, act, exp, $time, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: state after the most recent edge.
  // ---------------------------------------------------------------------------
  logic m_s1, m_s2;        // KEY[3] delayed by one and two edges
  logic win[$];            // last D synchronized samples
  logic m_kp, m_kp_d, m_press, m_start, m_bm, m_pending;
  int   m_streak;          // consecutive edges with run = 1
  int   m_hold;            // holdoff ticks still to elapse
  logic flip, n_kp, n_press, n_start, n_bm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      win.delete();
      m_kp = 1'b0; m_kp_d = 1'b0; m_press = 1'b0; m_start = 1'b0;
      m_bm = 1'b0; m_pending = 1'b0;
      m_streak = 0; m_hold = 0;
      cyc = -1;
    end else begin
      // Debounced state flips once the last D synchronized samples all
      // disagree with it (pressed = 0 samples, released = 1 samples).
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      flip = (win.size() == D);
      foreach (win[i]) if (win[i] != m_kp) flip = 1'b0;
      n_kp    = flip ? ~m_kp : m_kp;
      n_press = m_kp & ~m_kp_d;
      n_start = m_press & ~run;

      // Tick on every T-th consecutive running edge.
      m_streak = run ? m_streak + 1 : 0;
      n_bm     = run && (m_streak % T == 0);

      // Flap bookkeeping, using the tick and press visible before this edge.
      if (!run) begin
        m_pending = 1'b0;
        m_hold    = 0;
      end else if (m_pending) begin
        if (m_bm) begin
          m_pending = 1'b0;
          m_hold    = H;
        end
      end else if (m_hold > 0) begin
        if (m_bm) m_hold = m_hold - 1;
      end else if (m_press) begin
        m_pending = 1'b1;
      end

      m_s2    = m_s1;
      m_s1    = key[3];
      m_kp_d  = m_kp;
      m_kp    = n_kp;
      m_press = n_press;
      m_start = n_start;
      m_bm    = n_bm;
      cyc     = cyc + 1;
    end
  end

  // Single compare process: all outputs, every cycle, away from the edge.
  always @(negedge clk) begin
    check("bird_move",   int'(bird_move),   int'(m_bm));
    check("flap_req",    int'(flap_req),    int'(m_pending));
    check("start_pulse", int'(start_pulse), int'(m_start));
    check("key_pressed", int'(key_pressed), int'(m_kp));
  end

  // Return 1 ns after edge n (edges counted from 0 after reset release).
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int starts;
  int n0;
  int hold_left;
  bit seen;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Tick cadence and first flap, hand-computed edge numbers.
    wait_edge(2);  check("lit_bm_e2", int'(bird_move), 0);
    wait_edge(3);  check("lit_bm_e3", int'(bird_move), 1);
                   check("lit_flap_e3", int'(flap_req), 0);
    wait_edge(7);  check("lit_bm_e7", int'(bird_move), 1);
    wait_edge(9);  key[3] = 1'b0;
    wait_edge(13); check("lit_kp_e13", int'(key_pressed), 0);
    wait_edge(14); check("lit_kp_e14", int'(key_pressed), 1);
    wait_edge(15); check("lit_flap_e15", int'(flap_req), 0);
    wait_edge(16); check("lit_flap_e16", int'(flap_req), 1);
                   key[3] = 1'b1;
    wait_edge(19); check("lit_flap_e19", int'(flap_req), 1);
                   check("lit_bm_e19", int'(bird_move), 1);
    wait_edge(20); check("lit_flap_e20", int'(flap_req), 0);
    wait_edge(21); check("lit_kp_e21", int'(key_pressed), 0);
                   key[3] = 1'b0;  // press lands during holdoff
    wait_edge(26); check("lit_kp_e26", int'(key_pressed), 1);
    wait_edge(28); key[3] = 1'b1;
    wait_edge(30); check("lit_holdoff_drop", int'(flap_req), 0);
    wait_edge(33); check("lit_kp_e33", int'(key_pressed), 0);
                   key[3] = 1'b0;  // press after holdoff expired
    wait_edge(39); check("lit_flap_e39", int'(flap_req), 0);
    wait_edge(40); check("lit_flap_e40", int'(flap_req), 1);
                   key[3] = 1'b1;
    wait_edge(43); check("lit_flap_e43", int'(flap_req), 1);
    wait_edge(44); check("lit_flap_e44", int'(flap_req), 0);
    wait_edge(46); check("lit_kp_e46", int'(key_pressed), 0);

    // Bounce: toggle every 2 cycles, never long enough to be accepted.
    for (int i = 0; i < 20; i++) begin
      key[3] = ((i >> 1) & 1) != 0;
      cycles(1);
    end
    key[3] = 1'b1;
    cycles(6);
    check("lit_bounce_kp", int'(key_pressed), 0);
    check("lit_bounce_flap", int'(flap_req), 0);

    // Press while stopped: exactly one start pulse, no tick, no flap.
    run = 1'b0;
    cycles(2);
    key[3] = 1'b0;
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      starts += int'(start_pulse);
    end
    check("lit_start_once", starts, 1);
    check("lit_start_flap", int'(flap_req), 0);
    check("lit_start_bm", int'(bird_move), 0);
    key[3] = 1'b1;
    cycles(8);

    // Restart: first tick TICK_DIV edges after run rises.
    n0 = cyc;
    run = 1'b1;
    wait_edge(n0 + 3); check("lit_restart_e3", int'(bird_move), 0);
    wait_edge(n0 + 4); check("lit_restart_e4", int'(bird_move), 1);

    // Randomized phase: held key levels, occasional run drops and resets.
    hold_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_left == 0) begin
        key       = 4'($urandom);
        hold_left = $urandom_range(1, 8);
      end
      hold_left--;
      if ($urandom_range(0, 149) == 0) run = ~run;
      if ($urandom_range(0, 799) == 0) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      cycles(1);
    end

    // Asynchronous reset in the middle of a pending flap.
    run = 1'b1;
    key = 4'hF;
    cycles(8);
    key[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycles(1);
      if (flap_req) seen = 1'b1;
    end
    check("pending_reached", int'(seen), 1);
    #4 rst_n = 1'b0;
    #1;
    check("lit_rst_bm", int'(bird_move), 0);
    check("lit_rst_flap", int'(flap_req), 0);
    check("lit_rst_start", int'(start_pulse), 0);
    check("lit_rst_kp", int'(key_pressed), 0);
    key[3] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycles(20);
    check("lit_post_rst_flap", int'(flap_req), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
